// File: rtl/fifo_pkg.sv
// Shared async-FIFO package: pointer width/depth defaults and Gray/binary helpers.
// Helpers work on 32-bit values; callers zero-extend narrower pointers and truncate the result.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;
  localparam int PTR_W       = FIFO_ADDR_W + 1;
  localparam int DEPTH       = 2 ** FIFO_ADDR_W;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing into the local clock domain.
// Shared by the write-side and read-side pointer controllers.
module ptr_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = PTR_W,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer, full flag and fill level.
// Optional almost_full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = FIFO_ADDR_W,
  parameter int SYNC_STAGES  = 2
`ifdef FIFO_ALMOST_FULL_EN
  ,
  parameter int AFULL_THRESH = 2
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rptr_gray_in,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wptr_gray_out,
  output logic              full,
  output logic [ADDR_W:0]   level
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int K          = ADDR_W + 1;
  localparam int FIFO_DEPTH = 2 ** ADDR_W;

  logic [K-1:0] r_wbin;
  logic [K-1:0] r_wgray;
  logic         r_full;
  logic [K-1:0] r_level;
  logic [K-1:0] w_wbin_nx;
  logic [K-1:0] w_wgray_nx;
  logic [K-1:0] w_rq;
  logic [K-1:0] w_rbin;
  logic [K-1:0] w_full_ptr;
  logic [K-1:0] w_level_nx;
  logic         w_full_nx;

  ptr_sync #(
    .WIDTH  (K),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rptr_gray_in),
    .o_q (w_rq)
  );

  assign wr_accept = wr_en & ~r_full;

  always_comb begin
    if (wr_accept) begin
      w_wbin_nx = r_wbin + {{(K-1){1'b0}}, 1'b1};
    end else begin
      w_wbin_nx = r_wbin;
    end
  end

  assign w_wgray_nx = K'(bin2gray(32'(w_wbin_nx)));
  assign w_rbin     = K'(gray2bin(32'(w_rq)));
  // Full when the next write pointer is one lap ahead of the synchronised read pointer.
  assign w_full_ptr = {~w_rq[K-1:K-2], w_rq[K-3:0]};
  assign w_full_nx  = (w_wgray_nx == w_full_ptr);
  assign w_level_nx = w_wbin_nx - w_rbin;

`ifdef FIFO_ALMOST_FULL_EN
  logic [31:0] w_free;
  logic        w_afull_nx;
  logic        r_afull;

  assign w_free     = 32'(FIFO_DEPTH) - 32'(w_level_nx);
  assign w_afull_nx = (w_free <= 32'(AFULL_THRESH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_afull <= 1'b0;
    end else begin
      r_afull <= w_afull_nx;
    end
  end

  assign almost_full = r_afull;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wbin  <= {K{1'b0}};
      r_wgray <= {K{1'b0}};
      r_full  <= 1'b0;
      r_level <= {K{1'b0}};
    end else begin
      r_wbin  <= w_wbin_nx;
      r_wgray <= w_wgray_nx;
      r_full  <= w_full_nx;
      r_level <= w_level_nx;
    end
  end

  assign wr_addr       = r_wbin[ADDR_W-1:0];
  assign wptr_gray_out = r_wgray;
  assign full          = r_full;
  assign level         = r_level;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_W=2, SYNC_STAGES=2); model counts writes/reads as integers.
module tb_fifo_wptr_full;

  localparam int AW    = 2;
  localparam int K     = AW + 1;
  localparam int DEPTH = 2 ** AW;
  localparam int SS    = 2;
`ifdef FIFO_ALMOST_FULL_EN
  localparam int THR   = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [K-1:0]  rptr_gray_in = '0;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [K-1:0]  wptr_gray_out;
  logic          full;
  logic [K-1:0]  level;
`ifdef FIFO_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_wptr_full #(
    .ADDR_W       (AW),
    .SYNC_STAGES  (SS)
`ifdef FIFO_ALMOST_FULL_EN
    , .AFULL_THRESH (THR)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .rptr_gray_in  (rptr_gray_in),
    .wr_accept     (wr_accept),
    .wr_addr       (wr_addr),
    .wptr_gray_out (wptr_gray_out),
    .full          (full),
    .level         (level)
`ifdef FIFO_ALMOST_FULL_EN
    , .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total writes accepted, read count visible after the synchroniser delay.
  int m_wcnt;
  int m_level;
  bit m_full;
  bit m_af;
  int rd_dly [SS];
  bit last_acc;

  typedef struct {
    bit we;
    int rc;
    int e_gray;
    bit e_full;
    int e_level;
    bit e_acc;
  } vec_t;

  vec_t t1 [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int gray(input int n);
    int m;
    m = n % (2 * DEPTH);
    return m ^ (m >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_af    = 1'b0;
    for (int i = 0; i < SS; i++) rd_dly[i] = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".full"},  32'(full),          32'(m_full));
    chk({tag, ".level"}, 32'(level),         32'(m_level));
    chk({tag, ".addr"},  32'(wr_addr),       32'(m_wcnt % DEPTH));
    chk({tag, ".gray"},  32'(wptr_gray_out), 32'(gray(m_wcnt)));
`ifdef FIFO_ALMOST_FULL_EN
    chk({tag, ".afull"}, 32'(almost_full),   32'(m_af));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".full0"},  32'(full),          32'd0);
    chk({tag, ".level0"}, 32'(level),         32'd0);
    chk({tag, ".addr0"},  32'(wr_addr),       32'd0);
    chk({tag, ".gray0"},  32'(wptr_gray_out), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
    chk({tag, ".afull0"}, 32'(almost_full),   32'd0);
`endif
  endtask

  // One clock: drive at negedge, check accept before the edge, update model, check after the edge.
  task automatic cycle(input bit we, input int rc, input string tag);
    int rseen;
    @(negedge clk);
    wr_en        = we;
    rptr_gray_in = K'(gray(rc));
    #1;
    last_acc = we && !m_full;
    chk({tag, ".accept"}, 32'(wr_accept), 32'(last_acc));
    @(posedge clk);
    rseen = rd_dly[SS-1];
    for (int i = SS - 1; i > 0; i--) rd_dly[i] = rd_dly[i-1];
    rd_dly[0] = rc;
    if (last_acc) m_wcnt++;
    m_level = ((m_wcnt - rseen) % (2 * DEPTH) + 2 * DEPTH) % (2 * DEPTH);
    m_full  = (m_level == DEPTH);
`ifdef FIFO_ALMOST_FULL_EN
    m_af    = ((DEPTH - m_level) <= THR);
`endif
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst          = 1'b1;
    wr_en        = 1'b0;
    rptr_gray_in = '0;
    #1;
    model_reset();
    check_zero(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int rc;
    logic [K-1:0] prev_gray;

    t1[0] = '{1'b1, 0, 1, 1'b0, 1, 1'b1};
    t1[1] = '{1'b1, 0, 3, 1'b0, 2, 1'b1};
    t1[2] = '{1'b1, 0, 2, 1'b0, 3, 1'b1};
    t1[3] = '{1'b1, 0, 6, 1'b1, 4, 1'b1};
    t1[4] = '{1'b1, 0, 6, 1'b1, 4, 1'b0};

    model_reset();
    do_reset("rst");

    // Fill from empty; fifth write is dropped.
    for (int i = 0; i < 5; i++) begin
      cycle(t1[i].we, t1[i].rc, "t1");
      chk("t1.vec_acc",   32'(last_acc),      32'(t1[i].e_acc));
      chk("t1.vec_gray",  32'(wptr_gray_out), 32'(t1[i].e_gray));
      chk("t1.vec_full",  32'(full),          32'(t1[i].e_full));
      chk("t1.vec_level", 32'(level),         32'(t1[i].e_level));
    end

    // One read: full must hold for two cycles and clear on the third.
    cycle(1'b0, 1, "t2");
    cycle(1'b0, 1, "t2");
    chk("t2.full_not_early", 32'(full), 32'd1);
    cycle(1'b0, 1, "t2");
    chk("t2.full_clear", 32'(full),  32'd0);
    chk("t2.level3",     32'(level), 32'd3);
    chk("t2.next_addr",  32'(wr_addr), 32'd0);
    cycle(1'b1, 1, "t2");
    chk("t2.accepted", 32'(last_acc), 32'd1);

    // Continuous writes with a reader keeping pace; wraps the pointer twice.
    do_reset("t3rst");
    prev_gray = wptr_gray_out;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, m_wcnt, "t3");
      chk("t3.one_bit_step", 32'($countones(prev_gray ^ wptr_gray_out)), 32'd1);
      chk("t3.never_full", 32'(full), 32'd0);
      prev_gray = wptr_gray_out;
    end
    cycle(1'b1, m_wcnt, "t3");
    chk("t3.wbin5_addr", 32'(wr_addr), 32'd1);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_zero("t4");
    @(negedge clk);
    wr_en        = 1'b0;
    rptr_gray_in = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("t4.first_addr", 32'(wr_addr), 32'd0);
    cycle(1'b1, 0, "t4");
    chk("t4.first_gray", 32'(wptr_gray_out), 32'd1);

    // Fill, then hammer wr_en while full with a frozen read pointer.
    do_reset("t5rst");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 0, "t5fill");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 0, "t5");
      chk("t5.no_accept", 32'(last_acc),      32'd0);
      chk("t5.gray_hold", 32'(wptr_gray_out), 32'd6);
      chk("t5.level_hold", 32'(level),        32'd4);
    end

`ifdef FIFO_ALMOST_FULL_EN
    do_reset("t6rst");
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, "t6");
    chk("t6.afull_set", 32'(almost_full), 32'd1);
    chk("t6.level3",    32'(level),       32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1, "t6");
    chk("t6.afull_clr", 32'(almost_full), 32'd0);
    chk("t6.level2",    32'(level),       32'd2);
`endif

    // Randomised traffic against the model; reader never passes the writer.
    do_reset("rndrst");
    rc = 0;
    prev_gray = wptr_gray_out;
    for (int i = 0; i < 400; i++) begin
      if (rc < m_wcnt && ($urandom % 3) == 0) rc++;
      cycle(($urandom % 4) != 0, rc, "rnd");
      if (last_acc) begin
        chk("rnd.one_bit_step", 32'($countones(prev_gray ^ wptr_gray_out)), 32'd1);
      end else begin
        chk("rnd.gray_hold", 32'(wptr_gray_out), 32'(prev_gray));
      end
      prev_gray = wptr_gray_out;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
